// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-stage types and helpers: symbol and FSM state encodings,
// and the magnitude-category function used for DC and AC values.
package jpeg_pkg;

   localparam int BLOCK_SIZE = 64;
   localparam int SIZE_IN_W  = 16;

   typedef enum logic [1:0] {
      SYM_DC  = 2'd0,
      SYM_AC  = 2'd1,
      SYM_ZRL = 2'd2,
      SYM_EOB = 2'd3
   } sym_type_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DC   = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } rle_state_t;

   // Number of significant bits in |value|; 0 for a zero value.
   function automatic logic [3:0] size_category(input logic signed [SIZE_IN_W-1:0] value);
      logic [SIZE_IN_W-1:0] mag;
      logic [3:0]           size;
      mag  = value[SIZE_IN_W-1] ? $unsigned(-value) : $unsigned(value);
      size = '0;
      for (int i = 0; i < 15; i++) begin
         if (mag[i]) size = 4'(i + 1);
      end
      return size;
   endfunction

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder turning one zig-zag-ordered 8x8 block into DC/AC/ZRL/EOB symbols.
// Optional feature: define DC_DIFF_EN to emit DC as a difference from the previous block.
module rle_encoder
   import jpeg_pkg::*;
#(
   parameter int DATA_WIDTH = 11
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] zz_in [BLOCK_SIZE-1:0],
   input  logic                  zz_valid_in,
   output logic                  zz_ready_out,
   output logic [1:0]            sym_type_out,
   output logic [3:0]            sym_run_out,
   output logic [3:0]            sym_size_out,
   output logic [DATA_WIDTH:0]   sym_value_out,
   output logic                  sym_last_out,
   output logic                  sym_valid_out,
   input  logic                  sym_ready_in
);

   rle_state_t                   r_state, w_state_nxt;
   logic signed [DATA_WIDTH-1:0] r_coef [BLOCK_SIZE-1:0];
   logic [BLOCK_SIZE-1:0]        r_mask;
   logic [5:0]                   r_idx, w_idx_nxt;
   logic [3:0]                   r_run, w_run_nxt;

   sym_type_t                    r_sym_type, w_sym_type_nxt;
   logic [3:0]                   r_sym_run, w_sym_run_nxt;
   logic [3:0]                   r_sym_size, w_sym_size_nxt;
   logic signed [DATA_WIDTH:0]   r_sym_value, w_sym_value_nxt;
   logic                         r_sym_last, w_sym_last_nxt;
   logic                         r_sym_valid, w_sym_valid_nxt;

   logic                         w_hs, w_free, w_capture, w_scan_en, w_rest_zero;
   logic [5:0]                   w_scan_idx;
   logic [3:0]                   w_scan_run;
   logic signed [DATA_WIDTH:0]   w_dc_value, w_cur_value;

`ifdef DC_DIFF_EN
   logic signed [DATA_WIDTH-1:0] r_pred;
   logic                         w_pred_upd;

   assign w_dc_value = (DATA_WIDTH+1)'($signed(zz_in[0])) - (DATA_WIDTH+1)'(r_pred);
   assign w_pred_upd = (r_state == S_DC) && w_hs;
`else
   assign w_dc_value = (DATA_WIDTH+1)'($signed(zz_in[0]));
`endif

   assign w_hs      = r_sym_valid && sym_ready_in;
   assign w_free    = !r_sym_valid || sym_ready_in;
   assign w_capture = (r_state == S_IDLE) && zz_valid_in;

   // The DC handshake scans coefficient 1 in the same cycle so the first AC follows without a bubble.
   assign w_scan_idx  = (r_state == S_DC) ? 6'd1 : r_idx;
   assign w_scan_run  = (r_state == S_DC) ? 4'd0 : r_run;
   assign w_scan_en   = ((r_state == S_DC) && w_hs) || ((r_state == S_SCAN) && w_free);
   assign w_cur_value = (DATA_WIDTH+1)'(r_coef[w_scan_idx]);
   assign w_rest_zero = (r_mask >> w_scan_idx) == '0;

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_run_nxt       = r_run;
      w_sym_type_nxt  = r_sym_type;
      w_sym_run_nxt   = r_sym_run;
      w_sym_size_nxt  = r_sym_size;
      w_sym_value_nxt = r_sym_value;
      w_sym_last_nxt  = r_sym_last;
      w_sym_valid_nxt = r_sym_valid;

      case (r_state)
         S_IDLE: begin
            if (zz_valid_in) begin
               w_state_nxt     = S_DC;
               w_sym_valid_nxt = 1'b1;
               w_sym_type_nxt  = SYM_DC;
               w_sym_run_nxt   = 4'd0;
               w_sym_size_nxt  = size_category(SIZE_IN_W'(w_dc_value));
               w_sym_value_nxt = w_dc_value;
               w_sym_last_nxt  = 1'b0;
            end
         end
         S_DONE: begin
            if (w_hs) begin
               w_state_nxt     = S_IDLE;
               w_sym_valid_nxt = 1'b0;
            end
         end
         default: ;
      endcase

      if (w_scan_en) begin
         w_state_nxt     = S_SCAN;
         w_sym_valid_nxt = 1'b0;
         w_idx_nxt       = w_scan_idx + 6'd1;
         w_run_nxt       = w_scan_run;
         if (w_rest_zero) begin
            w_state_nxt     = S_DONE;
            w_sym_valid_nxt = 1'b1;
            w_sym_type_nxt  = SYM_EOB;
            w_sym_run_nxt   = 4'd0;
            w_sym_size_nxt  = 4'd0;
            w_sym_value_nxt = '0;
            w_sym_last_nxt  = 1'b1;
         end else if (r_mask[w_scan_idx]) begin
            w_sym_valid_nxt = 1'b1;
            w_sym_type_nxt  = SYM_AC;
            w_sym_run_nxt   = w_scan_run;
            w_sym_size_nxt  = size_category(SIZE_IN_W'(w_cur_value));
            w_sym_value_nxt = w_cur_value;
            w_sym_last_nxt  = (w_scan_idx == 6'd63);
            w_run_nxt       = 4'd0;
            if (w_scan_idx == 6'd63) w_state_nxt = S_DONE;
         end else if (w_scan_run == 4'd15) begin
            w_sym_valid_nxt = 1'b1;
            w_sym_type_nxt  = SYM_ZRL;
            w_sym_run_nxt   = 4'd15;
            w_sym_size_nxt  = 4'd0;
            w_sym_value_nxt = '0;
            w_sym_last_nxt  = 1'b0;
            w_run_nxt       = 4'd0;
         end else begin
            w_run_nxt = w_scan_run + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_run       <= '0;
         r_sym_type  <= SYM_DC;
         r_sym_run   <= '0;
         r_sym_size  <= '0;
         r_sym_value <= '0;
         r_sym_last  <= 1'b0;
         r_sym_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_run       <= w_run_nxt;
         r_sym_type  <= w_sym_type_nxt;
         r_sym_run   <= w_sym_run_nxt;
         r_sym_size  <= w_sym_size_nxt;
         r_sym_value <= w_sym_value_nxt;
         r_sym_last  <= w_sym_last_nxt;
         r_sym_valid <= w_sym_valid_nxt;
      end
   end

   // Block storage is pure data: only meaningful after a capture, so it is not reset.
   always_ff @(posedge clk_in) begin
      if (w_capture) begin
         for (int i = 0; i < BLOCK_SIZE; i++) begin
            r_coef[i] <= $signed(zz_in[i]);
            r_mask[i] <= |zz_in[i];
         end
      end
   end

`ifdef DC_DIFF_EN
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pred <= '0;
      end else if (w_pred_upd) begin
         r_pred <= r_coef[0];
      end
   end
`endif

   assign zz_ready_out  = (r_state == S_IDLE);
   assign sym_type_out  = r_sym_type;
   assign sym_run_out   = r_sym_run;
   assign sym_size_out  = r_sym_size;
   assign sym_value_out = r_sym_value;
   assign sym_last_out  = r_sym_last;
   assign sym_valid_out = r_sym_valid;

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: random and directed blocks against a
// queue-based symbol model; honours DC_DIFF_EN when defined.
module tb_rle_encoder;

   localparam int DW = 11;

   typedef struct packed {
      logic [1:0]  typ;
      logic [3:0]  run;
      logic [3:0]  size;
      logic [DW:0] value;
      logic        last;
   } sym_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] zz [63:0];
   logic          zz_valid = 1'b0;
   logic          zz_ready;
   logic [1:0]    sym_type;
   logic [3:0]    sym_run;
   logic [3:0]    sym_size;
   logic [DW:0]   sym_value;
   logic          sym_last;
   logic          sym_valid;
   logic          sym_ready = 1'b0;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cur_blk [64];
   int   prev_dc = 0;
   sym_t exp_q [$];
   sym_t got_q [$];

   int   r_tmo, r_lat, r_hold, r_ncyc, r_rdy;

   rle_encoder #(.DATA_WIDTH(DW)) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .zz_in         (zz),
      .zz_valid_in   (zz_valid),
      .zz_ready_out  (zz_ready),
      .sym_type_out  (sym_type),
      .sym_run_out   (sym_run),
      .sym_size_out  (sym_size),
      .sym_value_out (sym_value),
      .sym_last_out  (sym_last),
      .sym_valid_out (sym_valid),
      .sym_ready_in  (sym_ready)
   );

   always #5 clk = ~clk;

   function automatic int cat_of(input int v);
      int m = (v < 0) ? -v : v;
      int s = 0;
      while (m != 0) begin
         m = m >> 1;
         s++;
      end
      return s;
   endfunction

   function automatic sym_t mk(input int typ, input int run, input int value, input bit last);
      sym_t s;
      s.typ   = 2'(typ);
      s.run   = 4'(run);
      s.size  = 4'(cat_of(value));
      s.value = (DW+1)'(value);
      s.last  = last;
      return s;
   endfunction

   // Reference: DC, then each nonzero AC preceded by ZRLs for every full 16 zeros, then EOB if the tail is zero.
   task automatic build_expected();
      int dcv;
      int lastnz;
      int run;
      exp_q.delete();
      dcv = cur_blk[0];
`ifdef DC_DIFF_EN
      dcv = cur_blk[0] - prev_dc;
`endif
      prev_dc = cur_blk[0];
      exp_q.push_back(mk(0, 0, dcv, 1'b0));
      lastnz = 0;
      for (int i = 1; i < 64; i++) if (cur_blk[i] != 0) lastnz = i;
      run = 0;
      for (int i = 1; i <= lastnz; i++) begin
         if (cur_blk[i] == 0) begin
            run++;
         end else begin
            while (run >= 16) begin
               exp_q.push_back(mk(2, 15, 0, 1'b0));
               run -= 16;
            end
            exp_q.push_back(mk(1, run, cur_blk[i], i == 63));
            run = 0;
         end
      end
      if (lastnz < 63) exp_q.push_back(mk(3, 0, 0, 1'b1));
   endtask

   // Drives cur_blk in, then collects symbols until the last one handshakes.
   // mode 0: ready always; 1: random ready; 2: ready held low 10 cycles after the 2nd symbol.
   task automatic run_block(input int mode);
      int   cyc, stall_left, done, have_prev, stalled;
      logic [23:0] snap, prev_snap;
      logic rdy;
      r_tmo = 1; r_lat = 0; r_hold = 0; r_ncyc = 0; r_rdy = 0;
      got_q.delete();
      for (int w = 0; w < 200 && !zz_ready; w++) begin
         @(posedge clk); #1;
      end
      if (!zz_ready) return;
      for (int i = 0; i < 64; i++) zz[i] = DW'(cur_blk[i]);
      zz_valid = 1'b1;
      @(posedge clk); #1;
      zz_valid = 1'b0;
      r_lat = sym_valid;
      cyc = 0; stall_left = 0; done = 0; have_prev = 0; stalled = 0; prev_snap = '0;
      while (!done && cyc < 3000) begin
         snap = {sym_valid, sym_type, sym_run, sym_size, sym_value, sym_last};
         if (have_prev && snap !== prev_snap) r_hold++;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: begin
               if (got_q.size() == 2 && !stalled) begin
                  stall_left = 10;
                  stalled = 1;
               end
               rdy = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
         sym_ready = rdy;
         have_prev = sym_valid && !rdy;
         prev_snap = snap;
         if (sym_valid && rdy) begin
            got_q.push_back({sym_type, sym_run, sym_size, sym_value, sym_last});
            if (sym_last) begin
               done = 1;
               r_ncyc = cyc + 1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      sym_ready = 1'b0;
      r_rdy = zz_ready;
      r_tmo = !done;
   endtask

   task automatic gen_random();
      int d = $urandom_range(0, 4);
      for (int i = 0; i < 64; i++) begin
         cur_blk[i] = 0;
         if (i == 0 || $urandom_range(0, 7) < d) begin
            cur_blk[i] = int'($urandom_range(0, 2047)) - 1024;
            if (cur_blk[i] == 0 && i != 0) cur_blk[i] = 1;
         end
      end
      if ($urandom_range(0, 5) == 0) cur_blk[63] = -1024;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if ({zz_ready, sym_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/valid=%b, expected 10", {zz_ready, sym_valid});
      end
      n_cmp++;
      if ({sym_type, sym_run, sym_size, sym_value, sym_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_fields: t%0d r%0d s%0d v%0d l%0d, expected all 0",
                  sym_type, sym_run, sym_size, sym_value, sym_last);
      end
      prev_dc = 0;
   endtask

   task automatic test_directed();
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 64; i++) cur_blk[i] = (p == 3) ? 1 : 0;
         case (p)
            0: cur_blk[0] = 5;
            1: begin cur_blk[0] = -3; cur_blk[1] = 2; cur_blk[4] = -1; end
            2: begin cur_blk[0] = 12; cur_blk[20] = 7; end
            default: ;
         endcase
         build_expected();
         run_block(0);
         n_cmp++;
         if (r_tmo != 0 || r_lat != 1 || r_rdy != 1) begin
            n_fail++;
            $display("FAIL directed%0d_flow: timeout=%0d dc_next_cycle=%0d ready_after=%0d, expected 0 1 1",
                     p, r_tmo, r_lat, r_rdy);
         end
         if (p == 0 || p == 3) begin
            n_cmp++;
            if (r_ncyc != ((p == 0) ? 2 : 64)) begin
               n_fail++;
               $display("FAIL directed%0d_cycles: %0d, expected %0d", p, r_ncyc, (p == 0) ? 2 : 64);
            end
         end
         n_cmp++;
         if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL directed%0d_count: %0d symbols, expected %0d", p, got_q.size(), exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL directed%0d_sym%0d: got t%0d r%0d s%0d v%0d l%0d, expected t%0d r%0d s%0d v%0d l%0d",
                        p, k, got_q[k].typ, got_q[k].run, got_q[k].size, $signed(got_q[k].value), got_q[k].last,
                        exp_q[k].typ, exp_q[k].run, exp_q[k].size, $signed(exp_q[k].value), exp_q[k].last);
            end
         end
      end
   endtask

   task automatic test_dc_sequence();
      int dcs [2] = '{100, 90};
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 64; i++) cur_blk[i] = 0;
         cur_blk[0] = dcs[b];
         build_expected();
         run_block(0);
         n_cmp++;
         if (r_tmo != 0 || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL dc_seq%0d_count: timeout=%0d symbols=%0d, expected 0 2", b, r_tmo, got_q.size());
         end else if (got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL dc_seq%0d: got v%0d s%0d, expected v%0d s%0d", b, $signed(got_q[0].value),
                     got_q[0].size, $signed(exp_q[0].value), exp_q[0].size);
         end
      end
      n_cmp++;
`ifdef DC_DIFF_EN
      if (got_q.size() < 1 || $signed(got_q[0].value) != -10 || got_q[0].size != 4) begin
`else
      if (got_q.size() < 1 || $signed(got_q[0].value) != 90 || got_q[0].size != 7) begin
`endif
         n_fail++;
         $display("FAIL dc_second_value: got %0d symbols, first value %0d", got_q.size(),
                  (got_q.size() > 0) ? $signed(got_q[0].value) : 0);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 64; i++) cur_blk[i] = (i % 3 == 0) ? i - 30 : 0;
      build_expected();
      run_block(2);
      n_cmp++;
      if (r_tmo != 0 || r_hold != 0) begin
         n_fail++;
         $display("FAIL stall_hold: timeout=%0d changes_while_stalled=%0d, expected 0 0", r_tmo, r_hold);
      end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL stall_count: %0d symbols, expected %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         n_cmp++;
         if (got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL stall_sym%0d: got t%0d r%0d v%0d, expected t%0d r%0d v%0d", k, got_q[k].typ,
                     got_q[k].run, $signed(got_q[k].value), exp_q[k].typ, exp_q[k].run, $signed(exp_q[k].value));
         end
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 25; b++) begin
         gen_random();
         build_expected();
         run_block(1);
         n_cmp++;
         if (r_tmo != 0 || r_hold != 0 || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random%0d_flow: timeout=%0d hold_err=%0d symbols=%0d, expected 0 0 %0d",
                     b, r_tmo, r_hold, got_q.size(), exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL random%0d_sym%0d: got t%0d r%0d s%0d v%0d l%0d, expected t%0d r%0d s%0d v%0d l%0d",
                        b, k, got_q[k].typ, got_q[k].run, got_q[k].size, $signed(got_q[k].value), got_q[k].last,
                        exp_q[k].typ, exp_q[k].run, exp_q[k].size, $signed(exp_q[k].value), exp_q[k].last);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 3; b++) begin
         gen_random();
         build_expected();
         run_block(0);
         n_cmp++;
         if (r_tmo != 0 || r_rdy != 1 || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b%0d_flow: timeout=%0d ready_after=%0d symbols=%0d, expected 0 1 %0d",
                     b, r_tmo, r_rdy, got_q.size(), exp_q.size());
         end
         for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL b2b%0d_sym%0d: got t%0d r%0d v%0d, expected t%0d r%0d v%0d", b, k, got_q[k].typ,
                        got_q[k].run, $signed(got_q[k].value), exp_q[k].typ, exp_q[k].run, $signed(exp_q[k].value));
            end
         end
      end
   endtask

   task automatic test_reset_mid_block();
      for (int i = 0; i < 64; i++) begin
         cur_blk[i] = 2;
         zz[i] = DW'(2);
      end
      zz_valid = 1'b1;
      @(posedge clk); #1;
      zz_valid = 1'b0;
      sym_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sym_ready = 1'b0;
      prev_dc = 0;
      n_cmp++;
      if ({zz_ready, sym_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL midreset_ctrl: ready/valid=%b, expected 10", {zz_ready, sym_valid});
      end
      gen_random();
      cur_blk[0] = -77;
      build_expected();
      run_block(0);
      n_cmp++;
      if (r_tmo != 0 || got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL midreset_count: timeout=%0d symbols=%0d, expected 0 %0d", r_tmo, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         n_cmp++;
         if (got_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL midreset_sym%0d: got t%0d r%0d v%0d, expected t%0d r%0d v%0d", k, got_q[k].typ,
                     got_q[k].run, $signed(got_q[k].value), exp_q[k].typ, exp_q[k].run, $signed(exp_q[k].value));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) zz[i] = '0;
      test_reset();
      test_directed();
      test_dc_sequence();
      test_stall();
      test_random();
      test_back_to_back();
      test_reset_mid_block();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
